// File: rtl/fk_pkg.sv
// Shared kinematics definitions: discrete joint-angle table, trig lookup with
// default-zero semantics, and the search FSM state type.
package fk_pkg;

    localparam int ANGLE_COUNT = 9;
    localparam int SCALE       = 1000;
    localparam int ANGLE_W     = 16;
    localparam int TRIG_W      = 16;
    localparam int IDX_W       = 4;

    typedef logic signed [ANGLE_W-1:0] angle_t;
    typedef logic signed [TRIG_W-1:0]  trig_t;
    typedef logic [IDX_W-1:0]          idx_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam idx_t LAST_IDX = idx_t'(ANGLE_COUNT - 1);

    // Joint angle (degrees) for a table index.
    function automatic angle_t angle_at(input idx_t idx);
        case (idx)
            4'd0:    return 16'sd0;
            4'd1:    return 16'sd30;
            4'd2:    return 16'sd45;
            4'd3:    return 16'sd60;
            4'd4:    return 16'sd90;
            4'd5:    return 16'sd120;
            4'd6:    return 16'sd135;
            4'd7:    return 16'sd150;
            4'd8:    return 16'sd180;
            default: return 16'sd0;
        endcase
    endfunction

    // Scaled cosine; angles outside the table (including composites) give 0.
    function automatic trig_t cos_lookup(input angle_t a);
        case (a)
            16'sd0:   return 16'sd1000;
            16'sd30:  return 16'sd866;
            16'sd45:  return 16'sd707;
            16'sd60:  return 16'sd500;
            16'sd90:  return 16'sd0;
            16'sd120: return -16'sd500;
            16'sd135: return -16'sd707;
            16'sd150: return -16'sd866;
            16'sd180: return -16'sd1000;
            default:  return 16'sd0;
        endcase
    endfunction

    // Scaled sine; angles outside the table (including composites) give 0.
    function automatic trig_t sin_lookup(input angle_t a);
        case (a)
            16'sd0:   return 16'sd0;
            16'sd30:  return 16'sd500;
            16'sd45:  return 16'sd707;
            16'sd60:  return 16'sd866;
            16'sd90:  return 16'sd1000;
            16'sd120: return 16'sd866;
            16'sd135: return 16'sd707;
            16'sd150: return 16'sd500;
            16'sd180: return 16'sd0;
            default:  return 16'sd0;
        endcase
    endfunction

endpackage

// File: rtl/fk_trig_lut.sv
// Combinational cos/sin lookup for one (possibly composite) angle.
module fk_trig_lut
    import fk_pkg::*;
(
    input  angle_t angle,
    output trig_t  cos_val,
    output trig_t  sin_val
);

    assign cos_val = cos_lookup(angle);
    assign sin_val = sin_lookup(angle);

endmodule

// File: rtl/inverse_kinematics_search.sv
// Exhaustive inverse-kinematics search over the discrete 3-joint angle table.
// One candidate per cycle enters a 2-stage pipeline (lookup/products, then
// sum/error/compare); the lowest-error candidate, earliest on ties, is reported.
module inverse_kinematics_search #(
    parameter int SCALE = fk_pkg::SCALE,
    parameter int ACC_W = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] x_tgt,
    input  logic signed [31:0] y_tgt,
    input  logic signed [15:0] L1,
    input  logic signed [15:0] L2,
    input  logic signed [15:0] L3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] theta1,
    output logic signed [15:0] theta2,
    output logic signed [15:0] theta3,
    output logic [ACC_W-1:0]   err
);
    import fk_pkg::*;

    localparam logic signed [ACC_W-1:0] SCALE_W = ACC_W'(SCALE);

    state_t                   state;
    idx_t                     idx_reg [3];
    logic [1:0]               drain_cnt_reg;
    logic signed [ACC_W-1:0]  x_scaled_reg;
    logic signed [ACC_W-1:0]  y_scaled_reg;
    logic signed [15:0]       link_len_reg [3];

    logic accept;
    logic last_cand;

    assign accept    = (state == ST_IDLE) && in_valid;
    assign last_cand = (idx_reg[0] == LAST_IDX) && (idx_reg[1] == LAST_IDX) &&
                       (idx_reg[2] == LAST_IDX);

    // ---------------- Stage A: lookup and products ----------------
    angle_t                  base_angle [3];
    angle_t                  sum_angle  [3];
    trig_t                   cos_v      [3];
    trig_t                   sin_v      [3];
    logic signed [ACC_W-1:0] prod_x     [3];
    logic signed [ACC_W-1:0] prod_y     [3];

    // Composite angles accumulate along the chain, as in the FK block.
    assign sum_angle[0] = base_angle[0];
    assign sum_angle[1] = base_angle[0] + base_angle[1];
    assign sum_angle[2] = base_angle[0] + base_angle[1] + base_angle[2];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_link
            assign base_angle[gi] = angle_at(idx_reg[gi]);

            fk_trig_lut u_lut (
                .angle   (sum_angle[gi]),
                .cos_val (cos_v[gi]),
                .sin_val (sin_v[gi])
            );

            assign prod_x[gi] = ACC_W'(link_len_reg[gi]) * ACC_W'(cos_v[gi]);
            assign prod_y[gi] = ACC_W'(link_len_reg[gi]) * ACC_W'(sin_v[gi]);
        end
    endgenerate

    logic                    a_valid_reg;
    logic signed [ACC_W-1:0] prod_x_reg     [3];
    logic signed [ACC_W-1:0] prod_y_reg     [3];
    angle_t                  cand_angle_reg [3];

    // Register stage-A products with the candidate's joint angles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_reg <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                prod_x_reg[i]     <= '0;
                prod_y_reg[i]     <= '0;
                cand_angle_reg[i] <= '0;
            end
        end else begin
            a_valid_reg <= (state == ST_SEARCH);
            for (int i = 0; i < 3; i++) begin
                prod_x_reg[i]     <= prod_x[i];
                prod_y_reg[i]     <= prod_y[i];
                cand_angle_reg[i] <= base_angle[i];
            end
        end
    end

    // ---------------- Stage B: sum, error, compare ----------------
    logic signed [ACC_W-1:0] xs, ys, dx, dy;
    logic [ACC_W-1:0]        abs_dx, abs_dy, err_cand;

    // Manhattan distance between scaled target and candidate position.
    always_comb begin
        xs       = prod_x_reg[0] + prod_x_reg[1] + prod_x_reg[2];
        ys       = prod_y_reg[0] + prod_y_reg[1] + prod_y_reg[2];
        dx       = x_scaled_reg - xs;
        dy       = y_scaled_reg - ys;
        abs_dx   = dx[ACC_W-1] ? -dx : dx;
        abs_dy   = dy[ACC_W-1] ? -dy : dy;
        err_cand = abs_dx + abs_dy;
    end

    logic [ACC_W-1:0] best_err_reg;
    angle_t           best_theta_reg [3];

    // Track best candidate; strict compare keeps the earliest on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_err_reg <= '0;
            for (int i = 0; i < 3; i++) best_theta_reg[i] <= '0;
        end else if (accept) begin
            best_err_reg <= '1;
            for (int i = 0; i < 3; i++) best_theta_reg[i] <= '0;
        end else if (a_valid_reg && (err_cand < best_err_reg)) begin
            best_err_reg <= err_cand;
            for (int i = 0; i < 3; i++) best_theta_reg[i] <= cand_angle_reg[i];
        end
    end

    // ---------------- Control FSM with registered outputs ----------------
    // Command capture, candidate sequencing, drain timing and result hand-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            drain_cnt_reg <= '0;
            x_scaled_reg  <= '0;
            y_scaled_reg  <= '0;
            theta1        <= '0;
            theta2        <= '0;
            theta3        <= '0;
            err           <= '0;
            for (int i = 0; i < 3; i++) begin
                idx_reg[i]      <= '0;
                link_len_reg[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_scaled_reg    <= ACC_W'(x_tgt) * SCALE_W;
                        y_scaled_reg    <= ACC_W'(y_tgt) * SCALE_W;
                        link_len_reg[0] <= L1;
                        link_len_reg[1] <= L2;
                        link_len_reg[2] <= L3;
                        for (int i = 0; i < 3; i++) idx_reg[i] <= '0;
                        drain_cnt_reg   <= '0;
                        in_ready        <= 1'b0;
                        state           <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (last_cand) begin
                        for (int i = 0; i < 3; i++) idx_reg[i] <= '0;
                        drain_cnt_reg <= '0;
                        state         <= ST_DRAIN;
                    end else if (idx_reg[2] != LAST_IDX) begin
                        idx_reg[2] <= idx_reg[2] + 1'b1;
                    end else begin
                        idx_reg[2] <= '0;
                        if (idx_reg[1] != LAST_IDX) begin
                            idx_reg[1] <= idx_reg[1] + 1'b1;
                        end else begin
                            idx_reg[1] <= '0;
                            idx_reg[0] <= idx_reg[0] + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_reg == 2'd2) begin
                        theta1    <= best_theta_reg[0];
                        theta2    <= best_theta_reg[1];
                        theta3    <= best_theta_reg[2];
                        err       <= best_err_reg;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
